// File: rtl/vm_input_conditioner_if.sv
// vm_input_conditioner_if: raw board pins in, conditioned key/switch levels and pulses out
interface vm_input_conditioner_if #(
    parameter int N_KEYS = 4,
    parameter int N_SW   = 8
);
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_SW-1:0]   sw;
    logic [N_SW-1:0]   sw_level;
    logic [N_SW-1:0]   sw_rise;
    logic [N_SW-1:0]   sw_fall;

    modport master (
        output key_n, sw,
        input  key_level, key_press, key_release, sw_level, sw_rise, sw_fall
    );

    modport slave (
        input  key_n, sw,
        output key_level, key_press, key_release, sw_level, sw_rise, sw_fall
    );
endinterface

// File: rtl/vm_input_conditioner.sv
// vm_input_conditioner: synchronise and debounce pushbuttons and slide switches into levels and one-cycle pulses
module vm_input_conditioner #(
    parameter int N_KEYS          = 4,
    parameter int N_SW            = 8,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vm_input_conditioner_if.slave  bus_io
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int N     = N_KEYS + N_SW;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]     s1_q, s2_q, lvl_q, lvl_d, rise_q, rise_d, fall_q, fall_d, accept;
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            accept[i] = s2_q[i] != lvl_q[i] && cnt_q[i] == LAST;
            cnt_d[i]  = (s2_q[i] == lvl_q[i] || accept[i]) ? '0 : cnt_q[i] + 1'b1;
        end
        lvl_d  = lvl_q ^ accept;
        rise_d = accept & s2_q;
        fall_d = accept & ~s2_q;
    end

    // Keys are inverted before the synchroniser so every channel uses 1 = active.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            lvl_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            cnt_q  <= '{default: '0};
        end else begin
            s1_q   <= {bus_io.sw, ~bus_io.key_n};
            s2_q   <= s1_q;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus_io.key_level   = lvl_q[N_KEYS-1:0];
    assign bus_io.key_press   = rise_q[N_KEYS-1:0];
    assign bus_io.key_release = fall_q[N_KEYS-1:0];
    assign bus_io.sw_level    = lvl_q[N-1:N_KEYS];
    assign bus_io.sw_rise     = rise_q[N-1:N_KEYS];
    assign bus_io.sw_fall     = fall_q[N-1:N_KEYS];
endmodule
